// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state encoding, key-code to (row, col) lookup and shared
// constants for the Pmod KYPD emulator, the keypad decoder and their benches.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_B   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE_B = 3'd3,
    ST_GAP       = 3'd4
  } emu_state_e;

  localparam logic [3:0] NO_KEY_ROWS = 4'b1111;

  // Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
  function automatic logic [1:0] KEY_ROW(input logic [3:0] code);
    logic [1:0] r;
    case (code)
      4'h1, 4'h2, 4'h3, 4'hA: r = 2'd0;
      4'h4, 4'h5, 4'h6, 4'hB: r = 2'd1;
      4'h7, 4'h8, 4'h9, 4'hC: r = 2'd2;
      default:                r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] KEY_COL(input logic [3:0] code);
    logic [1:0] c;
    case (code)
      4'h1, 4'h4, 4'h7, 4'h0: c = 2'd0;
      4'h2, 4'h5, 4'h8, 4'hF: c = 2'd1;
      4'h3, 4'h6, 4'h9, 4'hE: c = 2'd2;
      default:                c = 2'd3;
    endcase
    return c;
  endfunction

  // Final count of an N-cycle phase; a zero length still occupies one cycle.
  function automatic int unsigned last_index(input int unsigned n);
    int unsigned v;
    if (n == 32'd0) begin
      v = 32'd0;
    end else begin
      v = n - 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/keypad_emulator_emu_timer.sv
// emu_timer: loadable down-counter shared by every emulator phase. expired_o is
// high while the count rests at zero; expiring_o says it will be zero next cycle.
module emu_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o,
  output logic         expiring_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expired_q;

  always_comb begin
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= {W{1'b0}};
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == {W{1'b0}});
    end
  end

  assign expired_o  = expired_q;
  assign expiring_o = (cnt_d == {W{1'b0}});

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: keypad end of the Pmod KYPD column-scan interface; presses,
// holds and releases one commanded key. Contact bounce: define KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 400_000,
  parameter int unsigned GAP_CYCLES    = 5_000,
  parameter int unsigned BOUNCE_CYCLES = 20_000,
  parameter int unsigned BOUNCE_PERIOD = 1_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       contact,
  output logic       done
);

  localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_BP = (BOUNCE_CYCLES > BOUNCE_PERIOD) ? BOUNCE_CYCLES : BOUNCE_PERIOD;
  localparam int unsigned MAX_N  = (MAX_HG > MAX_BP) ? MAX_HG : MAX_BP;
  localparam int unsigned CNT_W  = (MAX_N > 32'd1) ? $clog2(MAX_N) : 32'd1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(last_index(HOLD_CYCLES));
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(last_index(GAP_CYCLES));
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(last_index(BOUNCE_CYCLES));
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(last_index(BOUNCE_PERIOD));
`else
  localparam logic [CNT_W-1:0] EDGE_LAST = {CNT_W{1'b0}};
`endif

  emu_state_e       state_q, state_d;
  logic [3:0]       key_q;
  logic [3:0]       col_q;
  logic [3:0]       row_q, row_d;
  logic             contact_q, contact_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             accept_s;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_expired_s, tmr_expiring_s;
  logic [1:0]       tgt_row_s, tgt_col_s;

  assign accept_s  = cmd_valid & ready_q;
  assign tgt_row_s = KEY_ROW(key_q);
  assign tgt_col_s = KEY_COL(key_q);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        key_q <= cmd_key;
      end else begin
        key_q <= key_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = accept_s      ? ST_PRESS_B   : ST_IDLE;
      ST_PRESS_B:   state_d = tmr_expired_s ? ST_HOLD      : ST_PRESS_B;
      ST_HOLD:      state_d = tmr_expired_s ? ST_RELEASE_B : ST_HOLD;
      ST_RELEASE_B: state_d = tmr_expired_s ? ST_GAP       : ST_RELEASE_B;
      ST_GAP:       state_d = tmr_expired_s ? ST_IDLE      : ST_GAP;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Each phase reloads the shared timer on entry with its own last count.
  assign tmr_load_s = (state_d != state_q);

  always_comb begin
    case (state_d)
      ST_PRESS_B, ST_RELEASE_B: tmr_val_s = EDGE_LAST;
      ST_HOLD:                  tmr_val_s = HOLD_LAST;
      ST_GAP:                   tmr_val_s = GAP_LAST;
      default:                  tmr_val_s = {CNT_W{1'b0}};
    endcase
  end

  emu_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clk_100MHz),
    .rst_i      (reset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .expired_o  (tmr_expired_s),
    .expiring_o (tmr_expiring_s)
  );

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [CNT_W-1:0] per_q, per_d;
  logic             per_wrap_s;

  assign per_wrap_s = (per_q == {CNT_W{1'b0}});

  always_comb begin
    if ((state_d != state_q) || per_wrap_s) begin
      per_d = PER_LAST;
    end else begin
      per_d = per_q - CNT_W'(1'b1);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      per_q <= {CNT_W{1'b0}};
    end else begin
      per_q <= per_d;
    end
  end
`endif

  // Outputs are decoded from the next state and registered below.
  always_comb begin
    contact_d = 1'b0;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      ST_IDLE: ready_d = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_PRESS_B: begin
        if (state_q != ST_PRESS_B) begin
          contact_d = 1'b1;
        end else if (per_wrap_s) begin
          contact_d = ~contact_q;
        end else begin
          contact_d = contact_q;
        end
      end
      ST_RELEASE_B: begin
        if (state_q != ST_RELEASE_B) begin
          contact_d = 1'b0;
        end else if (per_wrap_s) begin
          contact_d = ~contact_q;
        end else begin
          contact_d = contact_q;
        end
      end
`else
      ST_PRESS_B:   contact_d = 1'b1;
      ST_RELEASE_B: contact_d = 1'b0;
`endif
      ST_HOLD: contact_d = 1'b1;
      ST_GAP:  done_d    = tmr_expiring_s;
      default: contact_d = 1'b0;
    endcase
  end

  always_comb begin
    row_d            = NO_KEY_ROWS;
    row_d[tgt_row_s] = ~(contact_q & ~col_q[tgt_col_s]);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      contact_q <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      col_q     <= 4'b1111;
      row_q     <= NO_KEY_ROWS;
    end else begin
      contact_q <= contact_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      col_q     <= col;
      row_q     <= row_d;
    end
  end

  assign cmd_ready = ready_q;
  assign contact   = contact_q;
  assign done      = done_q;
  assign row       = row_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed bench for keypad_emulator with a scoreboard of
// expected done cycles; short phase lengths keep the run small.
`timescale 1ns/1ps
module tb_keypad_emulator;

  localparam int HOLD = 20;
  localparam int GAP  = 5;
  localparam int BNC  = 12;
  localparam int PER  = 3;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int EDGE_LEN = BNC;
`else
  localparam int EDGE_LEN = 1;
`endif
  localparam int TOTAL = 2 * EDGE_LEN + HOLD + GAP;

  // Key map indexed by row*4 + col.
  localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'h0, 4'hF, 4'hE, 4'hD};

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd_key;
  logic       cmd_ready;
  logic [3:0] col;
  logic [3:0] row;
  logic       contact;
  logic       done;

  int cyc      = 0;
  int done_cnt = 0;
  int n_assert = 0;
  int n_fail   = 0;
  int sb_q[$];

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .GAP_CYCLES    (GAP),
    .BOUNCE_CYCLES (BNC),
    .BOUNCE_PERIOD (PER)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_key    (cmd_key),
    .cmd_ready  (cmd_ready),
    .col        (col),
    .row        (row),
    .contact    (contact),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic locate(input logic [3:0] k, output int r, output int c);
    r = -1;
    c = -1;
    for (int i = 0; i < 16; i++) begin
      if (KEYMAP[i] == k) begin
        r = i / 4;
        c = i % 4;
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_cmd(input logic [3:0] key, input bit keep, output int acc);
    bit got;
    got       = 1'b0;
    acc       = -1;
    cmd_key   = key;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      if (cmd_ready === 1'b1) begin
        got = 1'b1;
        acc = cyc + 1;
        sb_q.push_back(acc + TOTAL - 1);
      end
      @(negedge clk);
    end
    if (!keep) cmd_valid = 1'b0;
    checkb("accept", got, 1'b1);
  endtask

  // Returns at the negedge where done is high.
  task automatic wait_done(input string tag, output int dcyc);
    bit seen;
    int busy_ready;
    int exp;
    seen       = 1'b0;
    busy_ready = 0;
    dcyc       = -1;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
      end else begin
        if (cmd_ready !== 1'b0) busy_ready++;
        @(negedge clk);
      end
    end
    checkb({tag, "_done_seen"}, seen, 1'b1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : -2;
    checki({tag, "_done_cyc"}, dcyc, exp);
    checki({tag, "_busy_ready"}, busy_ready, 0);
  endtask

  initial begin
    int         acc, acc2, dcyc, dc0, r, c;
    logic [3:0] onehot, c_m1, c_m2, exp_row;
    logic [3:0] scan [6];
    logic       exp_contact;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    col       = 4'b1111;
    repeat (3) @(negedge clk);
    check4("rst_row", row, 4'b1111);
    checkb("rst_contact", contact, 1'b0);
    checkb("rst_done", done, 1'b0);
    checkb("rst_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkb("ready_after_rst", cmd_ready, 1'b1);

    // Key 1 on column 0, then row latency of a column change.
    col = 4'b1110;
    dc0 = done_cnt;
    send_cmd(4'h1, 1'b0, acc);
    wait_cyc(acc + EDGE_LEN + 4);
    check4("k1_hold_row", row, 4'b1110);
    checkb("k1_contact", contact, 1'b1);
    col = 4'b1101;
    @(negedge clk);
    check4("k1_lat1", row, 4'b1110);
    @(negedge clk);
    check4("k1_lat2", row, 4'b1111);
    col = 4'b1110;
    wait_done("k1", dcyc);
    @(negedge clk);
    checkb("k1_done_pulse", done, 1'b0);
    checkb("k1_ready_idle", cmd_ready, 1'b1);
    checki("k1_done_cnt", done_cnt - dc0, 1);

    // Reset in the middle of HOLD.
    col = 4'b1101;
    send_cmd(4'h5, 1'b0, acc);
    wait_cyc(acc + EDGE_LEN + 4);
    check4("k5_hold_row", row, 4'b1101);
    dc0   = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check4("midrst_row", row, 4'b1111);
    checkb("midrst_contact", contact, 1'b0);
    checkb("midrst_done", done, 1'b0);
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    checkb("midrst_ready", cmd_ready, 1'b1);
    repeat (TOTAL + 5) @(negedge clk);
    checki("midrst_no_done", done_cnt - dc0, 0);

    // cmd_valid held across two commands.
    col = 4'b1111;
    dc0 = done_cnt;
    send_cmd(4'h7, 1'b1, acc);
    wait_done("b2b7", dcyc);
    col = 4'b1101;
    send_cmd(4'h8, 1'b0, acc2);
    checki("b2b_accept_cyc", acc2, dcyc + 2);
    wait_cyc(acc2 + EDGE_LEN + 4);
    check4("k8_hold_row", row, 4'b1011);
    wait_done("b2b8", dcyc);
    @(negedge clk);
    checki("b2b_done_cnt", done_cnt - dc0, 2);

    // Key D against a scanning column pattern, including multi-column strobes.
    scan = '{4'b1110, 4'b1101, 4'b0110, 4'b1011, 4'b0111, 4'b1000};
    locate(4'hD, r, c);
    onehot = 4'b0001 << r;
    col    = 4'b1111;
    send_cmd(4'hD, 1'b0, acc);
    wait_cyc(acc + EDGE_LEN + 2);
    c_m1 = col;
    c_m2 = col;
    for (int i = 0; i < 13; i++) begin
      exp_row = (c_m2[c] == 1'b0) ? ~onehot : 4'b1111;
      check4("kD_scan_row", row, exp_row);
      c_m2 = c_m1;
      c_m1 = scan[(i / 2) % 6];
      col  = c_m1;
      @(negedge clk);
    end
    wait_done("kD", dcyc);
    @(negedge clk);

    // Every code with only its own column strobed.
    for (int k = 0; k < 16; k++) begin
      locate(4'(k), r, c);
      onehot = 4'b0001 << c;
      col    = ~onehot;
      send_cmd(4'(k), 1'b0, acc);
      wait_cyc(acc + EDGE_LEN + 4);
      onehot = 4'b0001 << r;
      check4($sformatf("key%0h_row", k), row, ~onehot);
      wait_done($sformatf("key%0h", k), dcyc);
      @(negedge clk);
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    col = 4'b0111;
    send_cmd(4'hB, 1'b0, acc);
    wait_cyc(acc + 1);
    for (int i = 0; i < BNC + 4; i++) begin
      exp_contact = (i >= BNC) ? 1'b1 : (((i / PER) % 2) == 0);
      checkb("kB_bounce_row1", row[1], ~exp_contact);
      @(negedge clk);
    end
    wait_done("kB", dcyc);
    @(negedge clk);
`endif

    checki("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
